fetch_queue: RTL

- Instruction buffer directly downstream of the predecode stage.
- Each cycle it accepts up to two predecoded instruction slots, with PC, instruction, prediction and exception fields, and stores them in program order in a circular buffer.
- It presents the two oldest entries to decode/rename, which dequeues 0, 1 or 2 per cycle.
- A flush from redirect or backend empties the queue.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between predecode and decode/rename.
// Accepts up to two predecoded slots per cycle into a circular buffer. It
// presents the two oldest entries, which the consumer dequeues 0, 1 or 2 at a
// time. A flush or reset empties the queue.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   io_flush                discard all entries and any same-cycle enqueue/dequeue
//   io_in_*1 / io_in_*2     two enqueue slots (valid, pc, insn, prediction, exception)
//   io_in_ready             queue has room for two entries (registered count only)
//   io_out_*1 / io_out_*2   oldest / second-oldest entry, data zeroed when not valid
//   io_out_ready1/2         consumer takes entry 1 / entry 2 (2 only together with 1)
//   io_count                current occupancy
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_flush,
    input  logic             io_in_valid1,
    input  logic             io_in_valid2,
    input  logic [31:0]      io_in_pc1,
    input  logic [31:0]      io_in_pc2,
    input  logic [31:0]      io_in_insn1,
    input  logic [31:0]      io_in_insn2,
    input  logic             io_in_pred_taken1,
    input  logic             io_in_pred_taken2,
    input  logic [31:0]      io_in_pred_target1,
    input  logic [31:0]      io_in_pred_target2,
    input  logic             io_in_excp_valid1,
    input  logic             io_in_excp_valid2,
    input  logic [5:0]       io_in_excp_cause1,
    input  logic [5:0]       io_in_excp_cause2,
    input  logic [31:0]      io_in_excp_tval1,
    input  logic [31:0]      io_in_excp_tval2,
    output logic             io_in_ready,
    output logic             io_out_valid1,
    output logic             io_out_valid2,
    output logic [31:0]      io_out_pc1,
    output logic [31:0]      io_out_pc2,
    output logic [31:0]      io_out_insn1,
    output logic [31:0]      io_out_insn2,
    output logic             io_out_pred_taken1,
    output logic             io_out_pred_taken2,
    output logic [31:0]      io_out_pred_target1,
    output logic [31:0]      io_out_pred_target2,
    output logic             io_out_excp_valid1,
    output logic             io_out_excp_valid2,
    output logic [5:0]       io_out_excp_cause1,
    output logic [5:0]       io_out_excp_cause2,
    output logic [31:0]      io_out_excp_tval1,
    output logic [31:0]      io_out_excp_tval2,
    input  logic             io_out_ready1,
    input  logic             io_out_ready2,
    output logic [PTR_W:0]   io_count
);

    localparam int ENTRY_W = 136;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    // Entry layout: {pc, insn, pred_taken, pred_target, excp_valid, excp_cause, excp_tval}
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;

    logic [ENTRY_W-1:0] w_in1, w_in2, w_out1, w_out2;
    logic [PTR_W-1:0]   w_head_p1, w_tail_p1;
    logic               w_enq1, w_enq2, w_deq1, w_deq2;
    logic [1:0]         w_enq_n, w_deq_n;

    assign w_in1 = {io_in_pc1, io_in_insn1, io_in_pred_taken1, io_in_pred_target1,
                    io_in_excp_valid1, io_in_excp_cause1, io_in_excp_tval1};
    assign w_in2 = {io_in_pc2, io_in_insn2, io_in_pred_taken2, io_in_pred_target2,
                    io_in_excp_valid2, io_in_excp_cause2, io_in_excp_tval2};

    assign w_head_p1 = r_head + PTR_W'(1);
    assign w_tail_p1 = r_tail + PTR_W'(1);

    // Ready looks only at the registered count, so a same-cycle dequeue never
    // opens space for a same-cycle enqueue.
    assign io_in_ready   = (DEPTH_C - r_count) >= TWO_C;
    assign io_out_valid1 = r_count >= (PTR_W+1)'(1);
    assign io_out_valid2 = r_count >= TWO_C;
    assign io_count      = r_count;

    // Slot 2 only moves when slot 1 does, keeping program order intact.
    assign w_enq1  = io_in_ready & io_in_valid1;
    assign w_enq2  = w_enq1 & io_in_valid2;
    assign w_deq1  = io_out_valid1 & io_out_ready1;
    assign w_deq2  = w_deq1 & io_out_valid2 & io_out_ready2;
    assign w_enq_n = {1'b0, w_enq1} + {1'b0, w_enq2};
    assign w_deq_n = {1'b0, w_deq1} + {1'b0, w_deq2};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (io_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_n);
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_count <= r_count + (PTR_W+1)'(w_enq_n) - (PTR_W+1)'(w_deq_n);
        end
    end

    // Storage carries no reset; entries are only observable once counted.
    always_ff @(posedge clock) begin
        if (w_enq1 && !io_flush) r_mem[r_tail]    <= w_in1;
        if (w_enq2 && !io_flush) r_mem[w_tail_p1] <= w_in2;
    end

    assign w_out1 = io_out_valid1 ? r_mem[r_head]    : '0;
    assign w_out2 = io_out_valid2 ? r_mem[w_head_p1] : '0;

    assign {io_out_pc1, io_out_insn1, io_out_pred_taken1, io_out_pred_target1,
            io_out_excp_valid1, io_out_excp_cause1, io_out_excp_tval1} = w_out1;
    assign {io_out_pc2, io_out_insn2, io_out_pred_taken2, io_out_pred_target2,
            io_out_excp_valid2, io_out_excp_cause2, io_out_excp_tval2} = w_out2;

endmodule
